// File: rtl/conv_mac_accum.sv
// Bias-seeded saturating accumulator for the conv core multiplier stream.
// Sums cfg_len products per output and emits cfg_num_out results per job.
module conv_mac_accum #(
   parameter int PROD_WIDTH = 21,
   parameter int ACC_WIDTH  = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ap_start,
   output logic                  ap_done,
   output logic                  ap_idle,
   input  logic [CNT_WIDTH-1:0]  cfg_len,
   input  logic [CNT_WIDTH-1:0]  cfg_num_out,
   input  logic [ACC_WIDTH-1:0]  cfg_bias,
   input  logic [PROD_WIDTH-1:0] prod_data,
   input  logic                  prod_valid,
   output logic                  prod_ready,
   output logic [ACC_WIDTH-1:0]  out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  out_ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_OUTPUT
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] bias_r;
   logic [CNT_WIDTH-1:0] len_r;
   logic [CNT_WIDTH-1:0] num_r;
   logic [CNT_WIDTH-1:0] len_cnt;
   logic [CNT_WIDTH-1:0] out_cnt;
   logic                 ovf;
   logic                 done_r;

   logic                 cfg_ok;
   logic                 start_ok;
   logic                 start_nil;
   logic                 prod_fire;
   logic                 out_fire;
   logic                 last_beat;
   logic                 last_out;
   logic [ACC_WIDTH:0]   sum;

   assign cfg_ok    = (cfg_len != '0) && (cfg_num_out != '0);
   assign start_ok  = (state == S_IDLE) && ap_start && cfg_ok;
   assign start_nil = (state == S_IDLE) && ap_start && !cfg_ok;
   assign prod_fire = prod_valid && prod_ready;
   assign out_fire  = out_valid && out_ready;
   assign last_beat = (len_cnt == len_r - CNT_WIDTH'(1));
   assign last_out  = (out_cnt == num_r - CNT_WIDTH'(1));

   // One extra bit on the adder exposes the carry used for saturation.
   assign sum = {1'b0, acc} + (ACC_WIDTH+1)'(prod_data);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      prod_ready = 1'b0;
      out_valid  = 1'b0;
      ap_idle    = 1'b0;
      unique case (state)
         S_IDLE: begin
            ap_idle = 1'b1;
            if (ap_start && cfg_ok) begin
               state_nxt = S_ACCUM;
            end
         end
         S_ACCUM: begin
            prod_ready = 1'b1;
            if (prod_valid && last_beat) begin
               state_nxt = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = last_out ? S_IDLE : S_ACCUM;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc     <= '0;
         bias_r  <= '0;
         len_r   <= '0;
         num_r   <= '0;
         len_cnt <= '0;
         out_cnt <= '0;
         ovf     <= 1'b0;
      end else if (start_ok) begin
         acc     <= cfg_bias;
         bias_r  <= cfg_bias;
         len_r   <= cfg_len;
         num_r   <= cfg_num_out;
         len_cnt <= '0;
         out_cnt <= '0;
         ovf     <= 1'b0;
      end else if (prod_fire) begin
         len_cnt <= len_cnt + CNT_WIDTH'(1);
         if (sum[ACC_WIDTH]) begin
            acc <= '1;
            ovf <= 1'b1;
         end else begin
            acc <= sum[ACC_WIDTH-1:0];
         end
      end else if (out_fire && !last_out) begin
         acc     <= bias_r;
         ovf     <= 1'b0;
         len_cnt <= '0;
         out_cnt <= out_cnt + CNT_WIDTH'(1);
      end
   end

   // Done fires for both a normal finish and a rejected empty job.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         done_r <= 1'b0;
      end else begin
         done_r <= start_nil || (out_fire && last_out);
      end
   end

   assign ap_done  = done_r;
   assign out_data = acc;
   assign out_last = out_valid && last_out;
   assign out_ovf  = out_valid && ovf;

endmodule
